rename_free_list: RTL
=====================

RENAME_FREE_LIST -- requirements
Module: rename_free_list

Interface
REQ-001 SHALL have parameter PHYS_REGS_SIZE, default 64, total physical registers.
REQ-002 SHALL have parameter ARCH_REGS, default 32, architectural registers initially mapped.
REQ-003 SHALL have parameter FRONTEND_WIDTH, default 2, allocate/release lanes per cycle.
REQ-004 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n input 1: reset, synchronous, active-low.
REQ-006 SHALL have port alloc_req_i input FRONTEND_WIDTH: per-lane request for a new physical destination (renamed instr with rd_v=1, rd!=0).
REQ-007 SHALL have port alloc_gnt_o output 1: all requested lanes granted this cycle.
REQ-008 SHALL have port alloc_preg_o output FRONTEND_WIDTH x PHYS_REGS_ADDR_SIZE: allocated register per lane, valid when lane requested and alloc_gnt_o=1.
REQ-009 SHALL have port release_v_i input FRONTEND_WIDTH: per-lane retirement freeing the previous mapping.
REQ-010 SHALL have port release_preg_i input FRONTEND_WIDTH x PHYS_REGS_ADDR_SIZE: register being freed per lane.
REQ-011 SHALL have port commit_alloc_i input FRONTEND_WIDTH: per-lane retirement of an instruction that had allocated (advances committed head).
REQ-012 SHALL have port flush_i input 1: pipeline flush; discard all uncommitted allocations.
REQ-013 SHALL have port free_count_o output PHYS_REGS_ADDR_SIZE: speculative free entries, 0..PHYS_REGS_SIZE-ARCH_REGS.
REQ-014 SHALL have port overflow_err_o output 1: sticky error, release into full list or commit beyond speculative head.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH=PHYS_REGS_SIZE-ARCH_REGS (32) entries, each PHYS_REGS_ADDR_SIZE bits.
REQ-016 Pointers SHALL be log2(DEPTH)+1 bits (wrap bit): spec_head, commit_head, tail; count = tail - spec_head modulo 2^(log2(DEPTH)+1).
REQ-017 Grant SHALL be all-or-nothing: alloc_gnt_o=1 iff popcount(alloc_req_i) <= free_count_o and flush_i=0; alloc_gnt_o=1 when alloc_req_i=0.
REQ-018 Grant and alloc_preg_o SHALL be combinational from registered state (zero latency); spec_head advances by popcount(alloc_req_i) on the next edge when granted.
REQ-019 Lanes SHALL be packed in order: the lowest requesting lane takes entry spec_head, the next requesting lane spec_head+1; non-requesting lanes consume nothing.
REQ-020 alloc_preg_o of non-requesting or ungranted lanes SHALL be 0.
REQ-021 Releases SHALL write release_preg_i in lane order at tail, tail+1, and advance tail by popcount(release_v_i); registers released in cycle N SHALL be allocatable no earlier than cycle N+1 (no bypass).
REQ-022 commit_head SHALL advance by popcount(commit_alloc_i) each cycle, independent of alloc and flush.
REQ-023 On flush_i=1: spec_head <= commit_head + popcount(commit_alloc_i); no grant that cycle; releases and commits that cycle are still applied.
REQ-024 Simultaneous alloc and release SHALL both apply; free_count next = count - granted + released.
REQ-025 Empty list (count=0) with any request SHALL give alloc_gnt_o=0 and no pointer change; count=1 with 2 requests likewise stalls both lanes.
REQ-026 Pointer arithmetic SHALL wrap modulo 2*DEPTH; wrap from entry 31 to entry 0 SHALL be seamless within one dual-lane operation.
REQ-027 overflow_err_o SHALL set when count + released > DEPTH or commit_head would pass spec_head, and hold until reset; offending writes are dropped.

Reset
REQ-028 On reset_n=0 at a rising edge: entry i <= ARCH_REGS+i, spec_head=commit_head=0, tail=DEPTH (wrap bit 1), overflow_err_o=0.
REQ-029 After reset free_count_o SHALL read 32, alloc_gnt_o=1, alloc_preg_o=0; reset mid-operation SHALL discard all in-flight allocations and releases.

Structure
REQ-030 PHYS_REGS_SIZE, PHYS_REGS_ADDR_SIZE, FRONTEND_WIDTH and a new ARCH_REGS=32 SHALL live in package riscv; a preg_t typedef SHALL be added there.
REQ-031 Block SHALL be a single module; no sub-module.

Verification
REQ-032 Reset, request 2'b11 -> alloc_gnt_o=1, pregs 32,33; next cycle free_count_o=30.
REQ-033 Allocate 31 regs, then request 2'b11 -> alloc_gnt_o=0, count stays 1; request 2'b10 -> lane1 gets 63.
REQ-034 Drain to 0, release 5 and 7 same cycle as request 2'b01 -> no grant that cycle; next cycle lane0 gets 5.
REQ-035 Allocate 4 (32..35), commit 2, flush -> free_count_o returns to 30; next request lane0 gets 34.
REQ-036 Fill/drain 40 times with random dual-lane mixes -> pointers wrap, no duplicate preg ever outstanding, overflow_err_o=0.
REQ-037 Release at count=32 -> overflow_err_o=1 sticky until reset_n=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core sizing constants and the physical register handle type.
package riscv;
  localparam int PHYS_REGS_SIZE      = 64;
  localparam int PHYS_REGS_ADDR_SIZE = $clog2(PHYS_REGS_SIZE);
  localparam int FRONTEND_WIDTH      = 2;
  localparam int ARCH_REGS           = 32;

  typedef logic [PHYS_REGS_ADDR_SIZE-1:0] preg_t;
endpackage

// File: rtl/rename_free_list.sv
// Physical register free list for the rename stage: a circular buffer with a
// speculative head (allocation), a committed head (flush recovery) and a tail (release).
module rename_free_list #(
  parameter  int PHYS_REGS_SIZE      = riscv::PHYS_REGS_SIZE,
  parameter  int ARCH_REGS           = riscv::ARCH_REGS,
  parameter  int FRONTEND_WIDTH      = riscv::FRONTEND_WIDTH,
  localparam int PHYS_REGS_ADDR_SIZE = $clog2(PHYS_REGS_SIZE)
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic [FRONTEND_WIDTH-1:0]                      alloc_req_i,
  output logic                                           alloc_gnt_o,
  output logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0] alloc_preg_o,
  input  logic [FRONTEND_WIDTH-1:0]                      release_v_i,
  input  logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0] release_preg_i,
  input  logic [FRONTEND_WIDTH-1:0]                      commit_alloc_i,
  input  logic                                           flush_i,
  output logic [PHYS_REGS_ADDR_SIZE-1:0]                 free_count_o,
  output logic                                           overflow_err_o
);

  localparam int DEPTH = PHYS_REGS_SIZE - ARCH_REGS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef logic [PTR_W-1:0]               ptr_t;
  typedef logic [PHYS_REGS_ADDR_SIZE-1:0] preg_t;

  function automatic ptr_t popcnt(input logic [FRONTEND_WIDTH-1:0] v);
    ptr_t c;
    c = '0;
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      c = c + ptr_t'(v[i]);
    end
    return c;
  endfunction

  preg_t entries_q [DEPTH];
  preg_t entries_d [DEPTH];
  ptr_t  spec_head_q, spec_head_d;
  ptr_t  commit_head_q, commit_head_d;
  ptr_t  tail_q, tail_d;
  logic  err_q, err_d;

  ptr_t  count;
  ptr_t  inflight;
  ptr_t  n_req, n_rel, n_com;
  ptr_t  roff, woff;
  logic  gnt;
  logic  rel_ok, com_ok;

  always_comb begin
    count    = tail_q - spec_head_q;
    inflight = spec_head_q - commit_head_q;
    n_req    = popcnt(alloc_req_i);
    n_rel    = popcnt(release_v_i);
    n_com    = popcnt(commit_alloc_i);

    // Grants look only at registered occupancy, so same-cycle releases never bypass.
    gnt    = !flush_i && (n_req <= count);
    rel_ok = (count + n_rel) <= ptr_t'(DEPTH);
    com_ok = n_com <= inflight;

    roff = spec_head_q;
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      alloc_preg_o[i] = '0;
      if (gnt && alloc_req_i[i]) begin
        alloc_preg_o[i] = entries_q[roff[IDX_W-1:0]];
        roff            = roff + ptr_t'(1);
      end
    end

    entries_d = entries_q;
    woff      = tail_q;
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      if (rel_ok && release_v_i[i]) begin
        entries_d[woff[IDX_W-1:0]] = release_preg_i[i];
        woff                       = woff + ptr_t'(1);
      end
    end
    tail_d = rel_ok ? tail_q + n_rel : tail_q;

    commit_head_d = com_ok ? commit_head_q + n_com : commit_head_q;

    // A flush rewinds to the committed head including this cycle's commits.
    spec_head_d = spec_head_q;
    if (flush_i) begin
      spec_head_d = commit_head_d;
    end else if (gnt) begin
      spec_head_d = spec_head_q + n_req;
    end

    err_d = err_q | !rel_ok | !com_ok;

    alloc_gnt_o    = gnt;
    free_count_o   = PHYS_REGS_ADDR_SIZE'(count);
    overflow_err_o = err_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= preg_t'(ARCH_REGS + i);
      end
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= ptr_t'(DEPTH);
      err_q         <= 1'b0;
    end else begin
      entries_q     <= entries_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      err_q         <= err_d;
    end
  end

endmodule
